// File: rtl/integrate_and_dump_clip.sv
// rtl/integrate_and_dump_clip.sv - integrate-and-dump decimator with shift and saturation
//
// Accumulates strobed signed samples over frames of N samples, then dumps the
// sum, shifts it right arithmetically and saturates it to the output width.
//
// Ports:
//   clk         - clock, all state updates on rising edge
//   rst         - asynchronous active-high reset
//   in          - signed input sample (WIDTH), valid when strobe_in is high
//   strobe_in   - input sample qualifier
//   decim       - decimation rate N (CNT_WIDTH), latched at frame start; 0 acts as 1
//   shift       - arithmetic right shift applied to the frame sum
//   out         - signed decimated sample (WIDTH), held between outputs
//   strobe_out  - one-cycle pulse marking a new out value
//   clipped     - set with strobe_out when out was saturated, held otherwise
//
// Build option: IDC_ROUND_NEAREST_EN selects round-half-up before the shift
// instead of truncation toward negative infinity.

module integrate_and_dump_clip #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic                 strobe_in,
    input  logic [CNT_WIDTH-1:0] decim,
    input  logic [4:0]           shift,
    output logic [WIDTH-1:0]     out,
    output logic                 strobe_out,
    output logic                 clipped
);

    localparam int          ACC_WIDTH = WIDTH + CNT_WIDTH;
    localparam int unsigned SH_MAX    = ACC_WIDTH - 1;

    // Saturation bounds, one bit wider than the accumulator so the rounding
    // increment can never wrap before the compare.
    localparam logic signed [ACC_WIDTH:0] MAX_V =
        {{(CNT_WIDTH + 1){1'b0}}, 1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_V =
        {{(CNT_WIDTH + 1){1'b1}}, 1'b1, {(WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]        nr_q, nr_d;
    logic [WIDTH-1:0]            out_q, out_d;
    logic                        strobe_out_q, strobe_out_d;
    logic                        clipped_q, clipped_d;

    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   sum_x;
    logic signed [ACC_WIDTH:0]   res;
    logic [CNT_WIDTH-1:0]        n_eff;
    logic                        last;
    int unsigned                 sh_amt;
    logic [WIDTH-1:0]            sat_val;
    logic                        sat_hit;

    always_comb begin
        in_ext = {{CNT_WIDTH{in[WIDTH-1]}}, in};
        sum    = acc_q + in_ext;

        // The rate is sampled only on the first strobe of a frame; later
        // strobes of the same frame use the latched copy.
        if (cnt_q == '0) begin
            n_eff = (decim == '0) ? CNT_WIDTH'(1) : decim;
        end else begin
            n_eff = nr_q;
        end
        last = (cnt_q == n_eff - 1'b1);

        sh_amt = {27'd0, shift};
        if (sh_amt > SH_MAX) begin
            sh_amt = SH_MAX;
        end

        sum_x = {sum[ACC_WIDTH-1], sum};
`ifdef IDC_ROUND_NEAREST_EN
        if (sh_amt != 0) begin
            sum_x = sum_x + ((ACC_WIDTH + 1)'(1) << (sh_amt - 1));
        end
`endif
        res = sum_x >>> sh_amt;

        if (res > MAX_V) begin
            sat_val = MAX_V[WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (res < MIN_V) begin
            sat_val = MIN_V[WIDTH-1:0];
            sat_hit = 1'b1;
        end else begin
            sat_val = res[WIDTH-1:0];
            sat_hit = 1'b0;
        end

        acc_d        = acc_q;
        cnt_d        = cnt_q;
        nr_d         = nr_q;
        out_d        = out_q;
        clipped_d    = clipped_q;
        strobe_out_d = 1'b0;

        if (strobe_in) begin
            nr_d = n_eff;
            if (last) begin
                acc_d        = '0;
                cnt_d        = '0;
                out_d        = sat_val;
                clipped_d    = sat_hit;
                strobe_out_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            nr_q         <= '0;
            out_q        <= '0;
            strobe_out_q <= 1'b0;
            clipped_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            nr_q         <= nr_d;
            out_q        <= out_d;
            strobe_out_q <= strobe_out_d;
            clipped_q    <= clipped_d;
        end
    end

    assign out        = out_q;
    assign strobe_out = strobe_out_q;
    assign clipped    = clipped_q;

endmodule

// File: tb/tb_integrate_and_dump_clip.sv
// tb/tb_integrate_and_dump_clip.sv - directed self-checking bench for integrate_and_dump_clip

module tb_integrate_and_dump_clip;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic        strobe_in;
    logic [7:0]  decim;
    logic [4:0]  shift;
    logic [15:0] out;
    logic        strobe_out;
    logic        clipped;

    int errors = 0;
    int checks = 0;

    integrate_and_dump_clip #(
        .WIDTH     (16),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .strobe_in  (strobe_in),
        .decim      (decim),
        .shift      (shift),
        .out        (out),
        .strobe_out (strobe_out),
        .clipped    (clipped)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; on return we sit at the next falling
    // edge, so outputs reflect the rising edge that sampled these inputs.
    task automatic drive(input logic s, input logic signed [15:0] v);
        in        = v;
        strobe_in = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in = '0; strobe_in = 1'b0; decim = 8'd4; shift = 5'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out !== 16'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", strobe_out); end
        checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL reset_clipped: got %b expected 0", clipped); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        decim = 8'd4; shift = 5'd2;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'sd100);
            checks++;
            if (strobe_out !== ((i % 4) == 3)) begin
                errors++; $display("FAIL basic_strobe[%0d]: got %b expected %b", i, strobe_out, ((i % 4) == 3));
            end
            if ((i % 4) == 3) begin
                checks++; if ($signed(out) !== 16'sd100) begin errors++; $display("FAIL basic_out: got %0d expected 100", $signed(out)); end
                checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL basic_clipped: got %b expected 0", clipped); end
            end
        end
        drive(1'b0, 16'sd0);
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", strobe_out); end
    endtask

    task automatic test_saturation;
        decim = 8'd4; shift = 5'd0;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'sd16000);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== 16'sd32767) begin errors++; $display("FAIL sat_pos_out: got %0d strobe %b expected 32767", $signed(out), strobe_out); end
        checks++; if (clipped !== 1'b1) begin errors++; $display("FAIL sat_pos_clipped: got %b expected 1", clipped); end
        for (int i = 0; i < 4; i++) drive(1'b1, -16'sd20000);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== -16'sd32768) begin errors++; $display("FAIL sat_neg_out: got %0d strobe %b expected -32768", $signed(out), strobe_out); end
        checks++; if (clipped !== 1'b1) begin errors++; $display("FAIL sat_neg_clipped: got %b expected 1", clipped); end
        drive(1'b0, 16'sd0);
        drive(1'b0, 16'sd0);
        checks++; if (clipped !== 1'b1 || $signed(out) !== -16'sd32768) begin errors++; $display("FAIL sat_hold: got %0d clipped %b expected -32768 clipped 1", $signed(out), clipped); end
    endtask

    task automatic test_reset_midframe;
        int pulses;
        decim = 8'd4; shift = 5'd0;
        drive(1'b1, 16'sd500);
        drive(1'b1, 16'sd500);
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL midrst_no_out: got %b expected 0", strobe_out); end
        strobe_in = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out !== 16'd0 || clipped !== 1'b0) begin errors++; $display("FAIL midrst_async_clear: got out %0d clipped %b expected 0 0", out, clipped); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'sd10);
            if (strobe_out === 1'b1) pulses++;
        end
        drive(1'b0, 16'sd0);
        if (strobe_out === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL midrst_pulses: got %0d expected 1", pulses); end
        checks++; if ($signed(out) !== 16'sd40) begin errors++; $display("FAIL midrst_out: got %0d expected 40", $signed(out)); end
    endtask

    task automatic test_rounding;
        logic signed [15:0] exp_v;
`ifdef IDC_ROUND_NEAREST_EN
        exp_v = 16'sd1;
`else
        exp_v = 16'sd0;
`endif
        decim = 8'd2; shift = 5'd2;
        drive(1'b1, 16'sd1);
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL round_early: got %b expected 0", strobe_out); end
        drive(1'b1, 16'sd2);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== exp_v) begin errors++; $display("FAIL round_out: got %0d strobe %b expected %0d", $signed(out), strobe_out, exp_v); end
    endtask

    task automatic test_gaps;
        logic signed [15:0] exp_v;
`ifdef IDC_ROUND_NEAREST_EN
        exp_v = -16'sd3;
`else
        exp_v = -16'sd4;
`endif
        decim = 8'd0; shift = 5'd1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, -16'sd7);
            checks++; if (strobe_out !== 1'b1 || $signed(out) !== exp_v) begin errors++; $display("FAIL gaps_out[%0d]: got %0d strobe %b expected %0d", k, $signed(out), strobe_out, exp_v); end
            for (int g = 0; g < 3; g++) drive(1'b0, 16'sd1234);
            checks++; if (strobe_out !== 1'b0 || $signed(out) !== exp_v || clipped !== 1'b0) begin errors++; $display("FAIL gaps_hold[%0d]: got %0d strobe %b clipped %b expected %0d 0 0", k, $signed(out), strobe_out, clipped, exp_v); end
        end
    endtask

    task automatic test_decim_change;
        decim = 8'd4; shift = 5'd0;
        drive(1'b1, 16'sd1);
        drive(1'b1, 16'sd2);
        decim = 8'd2;
        drive(1'b1, 16'sd3);
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL dchg_third: got %b expected 0", strobe_out); end
        drive(1'b1, 16'sd4);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== 16'sd10) begin errors++; $display("FAIL dchg_frame1: got %0d strobe %b expected 10", $signed(out), strobe_out); end
        drive(1'b1, 16'sd5);
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL dchg_mid2: got %b expected 0", strobe_out); end
        drive(1'b1, 16'sd6);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== 16'sd11) begin errors++; $display("FAIL dchg_frame2: got %0d strobe %b expected 11", $signed(out), strobe_out); end
    endtask

    task automatic test_shift_clamp;
        logic signed [15:0] exp_v;
`ifdef IDC_ROUND_NEAREST_EN
        exp_v = 16'sd0;
`else
        exp_v = -16'sd1;
`endif
        decim = 8'd1; shift = 5'd31;
        drive(1'b1, -16'sd100);
        checks++; if (strobe_out !== 1'b1 || $signed(out) !== exp_v) begin errors++; $display("FAIL clamp_out: got %0d strobe %b expected %0d", $signed(out), strobe_out, exp_v); end
        shift = 5'd24;
        drive(1'b1, 16'sd32767);
        checks++; if ($signed(out) !== 16'sd0 || clipped !== 1'b0) begin errors++; $display("FAIL clamp_pos: got %0d clipped %b expected 0 0", $signed(out), clipped); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_reset_midframe;
        test_rounding;
        test_gaps;
        test_decim_change;
        test_shift_clamp;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/integrate_and_dump_clip.md
INTEGRATE_AND_DUMP_CLIP -- requirements
Module: integrate_and_dump_clip

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of the signed input sample and output sample.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the decimation-rate input; ACC_WIDTH = WIDTH+CNT_WIDTH internally.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port in, input, WIDTH bits, a two's-complement sample, qualified by strobe_in.
REQ-006 The block SHALL have port strobe_in, input, 1 bit; a high cycle marks in as a valid sample.
REQ-007 The block SHALL have port decim, input, CNT_WIDTH bits, the decimation rate N (samples per output).
REQ-008 The block SHALL have port shift, input, 5 bits, the arithmetic right shift applied to the accumulated sum.
REQ-009 The block SHALL have port out, output reg, WIDTH bits, the signed decimated sample.
REQ-010 The block SHALL have port strobe_out, output reg, 1 bit, a single-cycle pulse marking out as new.
REQ-011 The block SHALL have port clipped, output reg, 1 bit, high with strobe_out when the current out was saturated.

Function
REQ-012 The block SHALL sign-extend each strobed sample to ACC_WIDTH and add it into the accumulator only in cycles with strobe_in high; non-strobe cycles SHALL leave all state unchanged.
REQ-013 The block SHALL latch decim into the effective rate N_r on the first strobe of each frame (sample counter = 0); decim changes mid-frame SHALL take effect at the next frame only.
REQ-014 The block SHALL treat decim = 0 and decim = 1 identically, as N_r = 1 (every strobe produces an output).
REQ-015 On the strobe that completes a frame (counter = N_r-1), the block SHALL form S = acc + sign-extended in, including that strobe's sample, and SHALL clear the accumulator and counter in the same cycle (dump).
REQ-016 The block SHALL compute R = S arithmetically shifted right by shift; shift values >= ACC_WIDTH SHALL be clamped to ACC_WIDTH-1.
REQ-017 The block SHALL saturate R to [-2^(WIDTH-1), 2^(WIDTH-1)-1], register it on out, and set clipped = 1 exactly when saturation changed the value.
REQ-018 strobe_out SHALL pulse high for exactly one cycle, the cycle after the frame-completing strobe_in (latency 1); out and clipped SHALL hold their values until the next output.
REQ-019 clipped SHALL be updated only on output cycles and SHALL hold its value otherwise.
REQ-020 Strobes need not be contiguous; gaps of any length SHALL not alter the frame count or the accumulated sum.

Reset
REQ-021 Asserting rst at any time SHALL immediately clear the accumulator, counter, N_r, out, strobe_out and clipped to 0, discarding any partial frame.
REQ-022 After rst deasserts, the first strobe_in SHALL start a new frame and latch decim.

Configuration
REQ-023 With macro IDC_ROUND_NEAREST_EN defined, the block SHALL add 2^(shift-1) to S before shifting when shift > 0 (round half up); without it, the shift SHALL truncate toward negative infinity; saturation SHALL apply after either.

Verification
REQ-024 WIDTH=16, CNT_WIDTH=8, decim=4, shift=2, in=100 strobed every cycle -> out=100, clipped=0, strobe_out pulses one cycle after every 4th strobe.
REQ-025 decim=4, shift=0, in=16000 x4 -> out=32767, clipped=1; then in=-20000 x4 -> out=-32768, clipped=1.
REQ-026 decim=2, shift=2, samples 1 then 2 -> out=1 with IDC_ROUND_NEAREST_EN, out=0 without.
REQ-027 decim=4, two strobes of 500, rst pulsed, then four strobes of 10, shift=0 -> exactly one output, out=40.
REQ-028 decim=0, shift=1, in=-7 strobed with 3-cycle gaps -> out=-4 (truncate) or -3 (round) after every strobe, latency 1.
REQ-029 decim changed from 4 to 2 after the 2nd strobe of a frame -> that frame still completes after 4 strobes; the next frame completes after 2.
